// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared 7-segment definitions: the active-low font table, the blank
//   pattern, and the per-digit capture slot used by the scan monitor.
//   The display driver imports the same font so both ends agree.
package seg7_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g, indexed by hex value.
    localparam logic [6:0] SEG7_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // One captured digit.
    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic       err;
    } slot_t;

endpackage

// File: rtl/seg7_scan_monitor_if.sv
// seg7_scan_monitor_if
//   Bundles the scanned display lines and the decoded-frame results.
//   master : display side / bench (drives an_n, seg_n, dp_n, clr)
//   slave  : the monitor (drives frame_valid, hex_out, dp_out, blank_out,
//            err_out, timeout)
interface seg7_scan_monitor_if #(
    parameter int NDIG = 8
);
    logic [NDIG-1:0]   an_n;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic              clr;
    logic              frame_valid;
    logic [4*NDIG-1:0] hex_out;
    logic [NDIG-1:0]   dp_out;
    logic [NDIG-1:0]   blank_out;
    logic [NDIG-1:0]   err_out;
    logic              timeout;

    modport master (
        output an_n, seg_n, dp_n, clr,
        input  frame_valid, hex_out, dp_out, blank_out, err_out, timeout
    );

    modport slave (
        input  an_n, seg_n, dp_n, clr,
        output frame_valid, hex_out, dp_out, blank_out, err_out, timeout
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational reverse font lookup.
//   seg_n_i  : active-low segment pattern {g..a}
//   nibble_o : matching hex value (0 when blank or unknown)
//   blank_o  : pattern is fully dark
//   err_o    : pattern is neither a font glyph nor blank
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       err_o
);
    always_comb begin
        nibble_o = '0;
        blank_o  = (seg_n_i == SEG7_BLANK);
        err_o    = (seg_n_i != SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg_n_i == SEG7_FONT[i]) begin
                nibble_o = 4'(i);
                err_o    = 1'b0;
            end
        end
    end
endmodule

// File: rtl/seg7_scan_monitor.sv
// seg7_scan_monitor
//   Read-back monitor for a multiplexed, active-low 7-segment display.
//   Registers the scan lines, waits for each digit to hold STABLE_CYC
//   identical samples, decodes it into a slot, and publishes a full frame
//   once every digit has been captured. Frames that take TIMEOUT cycles
//   are abandoned with a timeout pulse.
//   clk, rst : clock, synchronous active-high reset
//   mon      : slave side of seg7_scan_monitor_if (scan lines in, frame out)
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 2**20
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_monitor_if.slave  mon
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    logic [NDIG-1:0]   an_q, an_p_q;
    logic [6:0]        seg_q, seg_p_q;
    logic              dp_q, dp_p_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    slot_t             slot_q [NDIG];
    slot_t             slot_d [NDIG];
    logic [4*NDIG-1:0] hex_q, frm_hex;
    logic [NDIG-1:0]   dpo_q, blank_q, err_q, frm_dp, frm_blank, frm_err;
    logic              fv_q, to_q;

    logic              valid, same, capture, frame_load, tmo_hit;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_nib;
    logic              dec_blank, dec_err;

    seg7_pattern_decode u_dec (
        .seg_n_i  (seg_q),
        .nibble_o (dec_nib),
        .blank_o  (dec_blank),
        .err_o    (dec_err)
    );

    always_comb begin
        valid = $onehot(~an_q);
        idx   = '0;
        for (int i = 0; i < NDIG; i++)
            if (!an_q[i]) idx = IW'(i);
        same = ({an_q, seg_q, dp_q} == {an_p_q, seg_p_q, dp_p_q});

        if (!valid)               cnt_d = '0;
        else if (!same)           cnt_d = CW'(1);
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + CW'(1);

        // Fires only on the transition into saturation: once per dwell.
        capture = !mon.clr && valid && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

        slot_d = slot_q;
        seen_d = seen_q;
        if (capture) begin
            slot_d[idx] = '{nib: dec_nib, dp: ~dp_q, blank: dec_blank, err: dec_err};
            seen_d[idx] = 1'b1;
        end

        frame_load = capture && (&seen_d);
        // Completion on the last timeout cycle takes priority over the abort.
        tmo_hit    = !mon.clr && !frame_load && (tcnt_q == T_LAST);

        for (int i = 0; i < NDIG; i++) begin
            frm_hex[4*i +: 4] = slot_d[i].nib;
            frm_dp[i]         = slot_d[i].dp;
            frm_blank[i]      = slot_d[i].blank;
            frm_err[i]        = slot_d[i].err;
        end

        tcnt_d = tcnt_q + TW'(1);
        if (frame_load || tmo_hit) begin
            seen_d = '0;
            tcnt_d = '0;
        end
        if (mon.clr) begin
            seen_d = '0;
            cnt_d  = '0;
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q    <= '1;
            seg_q   <= SEG7_BLANK;
            dp_q    <= 1'b1;
            an_p_q  <= '1;
            seg_p_q <= SEG7_BLANK;
            dp_p_q  <= 1'b1;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            seen_q  <= '0;
            for (int i = 0; i < NDIG; i++) slot_q[i] <= '0;
            hex_q   <= '0;
            dpo_q   <= '0;
            blank_q <= '1;
            err_q   <= '0;
            fv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            an_q    <= mon.an_n;
            seg_q   <= mon.seg_n;
            dp_q    <= mon.dp_n;
            an_p_q  <= an_q;
            seg_p_q <= seg_q;
            dp_p_q  <= dp_q;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            seen_q  <= seen_d;
            slot_q  <= slot_d;
            fv_q    <= frame_load;
            to_q    <= tmo_hit;
            if (frame_load) begin
                hex_q   <= frm_hex;
                dpo_q   <= frm_dp;
                blank_q <= frm_blank;
                err_q   <= frm_err;
            end
        end
    end

    assign mon.frame_valid = fv_q;
    assign mon.timeout     = to_q;
    assign mon.hex_out     = hex_q;
    assign mon.dp_out      = dpo_q;
    assign mon.blank_out   = blank_q;
    assign mon.err_out     = err_q;
endmodule
